branch_resolve_queue: RTL and testbench

- In-order tracker for branches that the two-bit direction predictor has predicted but execute has not yet resolved.
- Fetch pushes each prediction (predicted direction plus predictor table index). Execute resolves the oldest entry with the actual outcome.
- The block drives the predictor's training strobe, taken and index inputs. On a mispredict it raises a one-cycle flush pulse.
- Sits between the predictor and the execute stage's branch unit.

---
 rtl/bp_pkg.sv | 14 +
 rtl/sat_counter.sv | 20 ++
 rtl/branch_resolve_queue.sv | 127 ++++++++++++
 tb/tb_branch_resolve_queue.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// Shared types and default sizing for the branch-resolution path.
package bp_pkg;

   localparam int unsigned BP_IDX_W   = 4;
   localparam int unsigned BP_Q_DEPTH = 8;
   localparam int unsigned BP_CNT_W   = 16;

   // One in-flight prediction at the default index width.
   typedef struct packed {
      logic                taken;
      logic [BP_IDX_W-1:0] idx;
   } bp_entry_t;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at its all-ones value instead of wrapping.
module sat_counter #(
   parameter int unsigned W = 16
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         inc,
   output logic [W-1:0] value
);

   // Count up on inc unless already saturated.
   always_ff @(posedge clock) begin
      if (reset) begin
         value <= '0;
      end else if (inc && (value != {W{1'b1}})) begin
         value <= value + W'(1);
      end
   end

endmodule

// File: rtl/branch_resolve_queue.sv
// In-order queue of predicted-but-unresolved branches. Resolves the oldest
// entry, trains the predictor one cycle later and flushes on a mispredict.
module branch_resolve_queue
   import bp_pkg::*;
#(
   parameter int unsigned DEPTH = BP_Q_DEPTH,
   parameter int unsigned IDX_W = BP_IDX_W,
   parameter int unsigned CNT_W = BP_CNT_W
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       pred_valid,
   input  logic                       pred_taken,
   input  logic [IDX_W-1:0]           pred_idx,
   output logic                       pred_ready,
   input  logic                       res_valid,
   input  logic                       res_taken,
   output logic                       upd_valid,
   output logic                       upd_taken,
   output logic [IDX_W-1:0]           upd_idx,
   output logic                       mispredict,
   output logic                       empty,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic [CNT_W-1:0]           resolved_cnt,
   output logic [CNT_W-1:0]           mispred_cnt
);

   localparam int unsigned PTR_W    = $clog2(DEPTH);
   localparam int unsigned CNT_BITS = $clog2(DEPTH+1);

   // Same layout as bp_entry_t, sized by this instance's IDX_W.
   typedef struct packed {
      logic             taken;
      logic [IDX_W-1:0] idx;
   } entry_t;

   entry_t              mem [DEPTH];
   logic [PTR_W-1:0]    head_q;
   logic [PTR_W-1:0]    tail_q;
   logic [CNT_BITS-1:0] count_q;

   entry_t head_entry;
   entry_t push_entry;
   logic   push_fire;
   logic   res_fire;
   logic   mis_fire;

   assign count      = count_q;
   assign empty      = (count_q == '0);
   // No full-bypass: a same-cycle resolve does not open a slot.
   assign pred_ready = (count_q != CNT_BITS'(DEPTH));

   // Decode handshakes and the mispredict condition for this cycle.
   always_comb begin
      head_entry       = mem[head_q];
      push_entry.taken = pred_taken;
      push_entry.idx   = pred_idx;
      push_fire        = pred_valid & pred_ready;
      res_fire         = res_valid & ~empty;
      mis_fire         = res_fire & (res_taken != head_entry.taken);
   end

   // Pointer and occupancy update; a mispredict discards all younger work.
   always_ff @(posedge clock) begin
      if (reset) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         if (res_fire) begin
            head_q <= head_q + PTR_W'(1);
         end
         if (mis_fire) begin
            tail_q  <= head_q + PTR_W'(1);
            count_q <= '0;
         end else begin
            if (push_fire) begin
               tail_q <= tail_q + PTR_W'(1);
            end
            count_q <= count_q + CNT_BITS'(push_fire) - CNT_BITS'(res_fire);
         end
      end
   end

   // Entry storage; contents are don't-care until written, so no reset.
   always_ff @(posedge clock) begin
      if (push_fire && !mis_fire) begin
         mem[tail_q] <= push_entry;
      end
   end

   // Registered training and flush outputs; taken/idx hold between resolves.
   always_ff @(posedge clock) begin
      if (reset) begin
         upd_valid  <= 1'b0;
         upd_taken  <= 1'b0;
         upd_idx    <= '0;
         mispredict <= 1'b0;
      end else begin
         upd_valid  <= res_fire;
         mispredict <= mis_fire;
         if (res_fire) begin
            upd_taken <= res_taken;
            upd_idx   <= head_entry.idx;
         end
      end
   end

   sat_counter #(
      .W (CNT_W)
   ) u_resolved_cnt (
      .clock (clock),
      .reset (reset),
      .inc   (res_fire),
      .value (resolved_cnt)
   );

   sat_counter #(
      .W (CNT_W)
   ) u_mispred_cnt (
      .clock (clock),
      .reset (reset),
      .inc   (mis_fire),
      .value (mispred_cnt)
   );

endmodule

// File: tb/tb_branch_resolve_queue.sv
// Randomized and directed bench for branch_resolve_queue against a queue model.
module tb_branch_resolve_queue;

   localparam int DEPTH   = 8;
   localparam int IDX_W   = 4;
   localparam int CNT_W   = 5;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   typedef struct packed {
      logic             taken;
      logic [IDX_W-1:0] idx;
   } ent_t;

   logic                       clock;
   logic                       reset;
   logic                       pred_valid;
   logic                       pred_taken;
   logic [IDX_W-1:0]           pred_idx;
   logic                       pred_ready;
   logic                       res_valid;
   logic                       res_taken;
   logic                       upd_valid;
   logic                       upd_taken;
   logic [IDX_W-1:0]           upd_idx;
   logic                       mispredict;
   logic                       empty;
   logic [$clog2(DEPTH+1)-1:0] count;
   logic [CNT_W-1:0]           resolved_cnt;
   logic [CNT_W-1:0]           mispred_cnt;

   branch_resolve_queue #(
      .DEPTH (DEPTH),
      .IDX_W (IDX_W),
      .CNT_W (CNT_W)
   ) dut (
      .clock        (clock),
      .reset        (reset),
      .pred_valid   (pred_valid),
      .pred_taken   (pred_taken),
      .pred_idx     (pred_idx),
      .pred_ready   (pred_ready),
      .res_valid    (res_valid),
      .res_taken    (res_taken),
      .upd_valid    (upd_valid),
      .upd_taken    (upd_taken),
      .upd_idx      (upd_idx),
      .mispredict   (mispredict),
      .empty        (empty),
      .count        (count),
      .resolved_cnt (resolved_cnt),
      .mispred_cnt  (mispred_cnt)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int checks = 0;
   int errors = 0;

   // Reference model state.
   ent_t             q[$];
   bit               e_uv;
   bit               e_ut;
   bit               e_mis;
   logic [IDX_W-1:0] e_ui;
   int               e_rc;
   int               e_mc;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic check_all();
      check("upd_valid", 32'(upd_valid), 32'(e_uv));
      check("upd_taken", 32'(upd_taken), 32'(e_ut));
      check("upd_idx", 32'(upd_idx), 32'(e_ui));
      check("mispredict", 32'(mispredict), 32'(e_mis));
      check("count", 32'(count), 32'(q.size()));
      check("empty", 32'(empty), 32'(q.size() == 0));
      check("pred_ready", 32'(pred_ready), 32'(q.size() != DEPTH));
      check("resolved_cnt", 32'(resolved_cnt), 32'(e_rc));
      check("mispred_cnt", 32'(mispred_cnt), 32'(e_mc));
   endtask

   // One clock with the given inputs; model advanced, then outputs checked.
   task automatic step(input bit pv, input bit pt, input logic [IDX_W-1:0] pi,
                       input bit rv, input bit rt);
      ent_t h;
      ent_t n;
      bit   push;
      bit   res;
      bit   mis;
      pred_valid = pv;
      pred_taken = pt;
      pred_idx   = pi;
      res_valid  = rv;
      res_taken  = rt;
      push = pv && (q.size() != DEPTH);
      res  = rv && (q.size() != 0);
      mis  = 1'b0;
      e_uv = res;
      if (res) begin
         h    = q.pop_front();
         mis  = (rt != h.taken);
         e_ut = rt;
         e_ui = h.idx;
         if (e_rc < CNT_MAX) e_rc++;
         if (mis) begin
            q.delete();
            if (e_mc < CNT_MAX) e_mc++;
         end
      end
      e_mis = mis;
      if (push && !mis) begin
         n.taken = pt;
         n.idx   = pi;
         q.push_back(n);
      end
      @(posedge clock);
      #1;
      check_all();
   endtask

   task automatic do_reset(input bit rv);
      reset      = 1'b1;
      pred_valid = 1'b1;
      pred_taken = 1'b1;
      pred_idx   = 4'hA;
      res_valid  = rv;
      res_taken  = 1'b0;
      @(posedge clock);
      #1;
      q.delete();
      e_uv  = 0;
      e_ut  = 0;
      e_ui  = '0;
      e_mis = 0;
      e_rc  = 0;
      e_mc  = 0;
      check_all();
      reset      = 1'b0;
      pred_valid = 1'b0;
      res_valid  = 1'b0;
   endtask

   function automatic bit head_taken();
      return (q.size() != 0) ? q[0].taken : 1'b0;
   endfunction

   initial begin
      bit pv, pt, rv, rt;
      logic [IDX_W-1:0] pi;
      reset      = 1'b1;
      pred_valid = 1'b0;
      pred_taken = 1'b0;
      pred_idx   = '0;
      res_valid  = 1'b0;
      res_taken  = 1'b0;
      e_ut = 0;
      e_ui = '0;
      @(posedge clock);
      do_reset(1'b0);

      // Idle after reset.
      step(0, 0, 0, 0, 0);

      // Single push then correct resolve.
      step(1, 1, 4'd3, 0, 0);
      step(0, 0, 0, 1, 1);

      // Fill, then a push while full with a simultaneous resolve is refused.
      for (int i = 0; i < DEPTH; i++) step(1, i[0], IDX_W'(i + 4), 0, 0);
      step(1, 1, 4'd9, 1, head_taken());
      while (q.size() != 0) step(0, 0, 0, 1, head_taken());

      // Mispredict flushes younger entries and drops the same-cycle push.
      step(1, 1, 4'd1, 0, 0);
      step(1, 1, 4'd2, 0, 0);
      step(1, 1, 4'd3, 0, 0);
      step(1, 1, 4'd5, 1, 0);
      step(0, 0, 0, 0, 0);

      // Back-to-back push+resolve pairs, wrapping both pointers.
      step(1, 0, 4'd0, 0, 0);
      for (int i = 1; i <= 20; i++) step(1, i[1], IDX_W'(i), 1, head_taken());
      step(0, 0, 0, 1, head_taken());

      // Resolve while empty is ignored.
      step(0, 0, 0, 1, 1);
      step(0, 0, 0, 1, 0);

      // Reset with entries in flight and a resolve firing.
      for (int i = 0; i < 4; i++) step(1, 1, IDX_W'(i), 0, 0);
      do_reset(1'b1);
      step(0, 0, 0, 0, 0);

      // Random traffic; mostly-correct outcomes so the queue stays populated.
      for (int i = 0; i < 600; i++) begin
         pv = ($urandom_range(0, 9) < 7);
         pt = 1'($urandom);
         pi = IDX_W'($urandom);
         rv = ($urandom_range(0, 9) < 5);
         rt = ($urandom_range(0, 5) != 0) ? head_taken() : 1'($urandom);
         step(pv, pt, pi, rv, rt);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
